calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 27 ++
 rtl/digit_accum.sv | 33 +++
 rtl/calc_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, sequencer state encoding and small helpers for the calculator datapath.
// Used by the sequencer, the ALU and the display blocks.
package calc_pkg;

    localparam logic [3:0] KEY_CE       = 4'hA;
    localparam logic [3:0] KEY_SUB      = 4'hB;
    localparam logic [3:0] KEY_ADD      = 4'hC;
    localparam logic [3:0] KEY_IGUAL    = 4'hD;
    localparam logic [3:0] KEY_RECOVERY = 4'hE;
    localparam logic [3:0] KEY_SAVE     = 4'hF;

    typedef enum logic [1:0] {
        ST_VALUE_A     = 2'b00,
        ST_VALUE_B     = 2'b01,
        ST_VALUE_IGUAL = 2'b10,
        ST_ERROR       = 2'b11
    } calc_state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] key);
        return (key == KEY_ADD) || (key == KEY_SUB);
    endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal entry step: value*10 + digit with digit count and range check.
// Purely combinational, no backpressure; a zero count means the next digit replaces the value.
module digit_accum #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [CW-1:0]    count_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] value_o,
    output logic [CW-1:0]    count_o,
    output logic             ovf_o
);

    localparam int EW = WIDTH + 4;

    logic [WIDTH-1:0] base;
    logic [EW-1:0]    prod;
    logic             too_many;
    logic             too_big;

    always_comb begin
        base     = (count_i == '0) ? '0 : value_i;
        prod     = EW'(base) * EW'(4'd10) + EW'(digit_i);
        too_many = ({1'b0, count_i} >= (CW + 1)'(MAX_DIGITS));
        too_big  = (prod > EW'({WIDTH{1'b1}}));
        ovf_o    = too_many | too_big;
        value_o  = prod[WIDTH-1:0];
        count_o  = count_i + CW'(1);
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: operand entry, operator chaining, memory save/recall.
// Key effects and keyAck land one cycle after the ready rising edge is sampled; no backpressure.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             Clock,
    input  logic             clearIn,
    input  logic             ready,
    input  logic [3:0]       tecla,
    input  logic [WIDTH-1:0] memoryIn,
    input  logic [WIDTH-1:0] result,
    input  logic             resultOvf,
    output logic [WIDTH-1:0] numberA,
    output logic [WIDTH-1:0] numberB,
    output logic             operation,
    output logic [WIDTH-1:0] memoryOut,
    output logic             memWrite,
    output logic             keyAck,
    output logic             entryOvf,
    output logic [1:0]       estate
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    calc_state_t      state_q;
    logic [WIDTH-1:0] num_a_q;
    logic [WIDTH-1:0] num_b_q;
    logic             op_q;
    logic [WIDTH-1:0] mem_out_q;
    logic             mem_wr_q;
    logic             key_ack_q;
    logic             ent_ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             b_ent_q;
    logic             ready_q;
    logic             key_stb_q;
    logic [3:0]       key_q;

    logic [WIDTH-1:0] acc_val_d;
    logic [CW-1:0]    acc_cnt_d;
    logic             acc_ovf_d;
    logic             in_b;

    assign in_b = (state_q == ST_VALUE_B);

    digit_accum #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CW         (CW)
    ) u_accum (
        .value_i (in_b ? num_b_q : num_a_q),
        .count_i (cnt_q),
        .digit_i (key_q),
        .value_o (acc_val_d),
        .count_o (acc_cnt_d),
        .ovf_o   (acc_ovf_d)
    );

    // Edge history resets to 1 so a key still held across reset is never taken.
    always_ff @(posedge Clock or negedge clearIn) begin
        if (!clearIn) begin
            state_q   <= ST_VALUE_A;
            num_a_q   <= '0;
            num_b_q   <= '0;
            op_q      <= 1'b0;
            mem_out_q <= '0;
            mem_wr_q  <= 1'b0;
            key_ack_q <= 1'b0;
            ent_ovf_q <= 1'b0;
            cnt_q     <= '0;
            b_ent_q   <= 1'b0;
            ready_q   <= 1'b1;
            key_stb_q <= 1'b0;
            key_q     <= '0;
        end else begin
            ready_q   <= ready;
            key_stb_q <= ready & ~ready_q;
            key_q     <= tecla;
            key_ack_q <= key_stb_q;
            mem_wr_q  <= 1'b0;

            if (key_stb_q) begin
                unique case (state_q)
                    ST_VALUE_A, ST_VALUE_B: begin
                        if (is_digit(key_q)) begin
                            if (acc_ovf_d) begin
                                ent_ovf_q <= 1'b1;
                            end else begin
                                cnt_q <= acc_cnt_d;
                                if (in_b) begin
                                    num_b_q <= acc_val_d;
                                    b_ent_q <= 1'b1;
                                end else begin
                                    num_a_q <= acc_val_d;
                                end
                            end
                        end else if (is_operator(key_q)) begin
                            if (!in_b) begin
                                op_q    <= (key_q == KEY_SUB);
                                num_b_q <= '0;
                                cnt_q   <= '0;
                                b_ent_q <= 1'b0;
                                state_q <= ST_VALUE_B;
                            end else if (!b_ent_q) begin
                                op_q <= (key_q == KEY_SUB);
                            end else if (resultOvf) begin
                                state_q <= ST_ERROR;
                            end else begin
                                num_a_q <= result;
                                num_b_q <= '0;
                                op_q    <= (key_q == KEY_SUB);
                                cnt_q   <= '0;
                                b_ent_q <= 1'b0;
                            end
                        end else begin
                            case (key_q)
                                KEY_IGUAL: begin
                                    if (in_b) begin
                                        state_q <= resultOvf ? ST_ERROR : ST_VALUE_IGUAL;
                                    end
                                end
                                KEY_SAVE: begin
                                    mem_out_q <= in_b ? num_b_q : num_a_q;
                                    mem_wr_q  <= 1'b1;
                                end
                                KEY_RECOVERY: begin
                                    cnt_q <= '0;
                                    if (in_b) begin
                                        num_b_q <= memoryIn;
                                        b_ent_q <= 1'b1;
                                    end else begin
                                        num_a_q <= memoryIn;
                                    end
                                end
                                KEY_CE: begin
                                    cnt_q     <= '0;
                                    ent_ovf_q <= 1'b0;
                                    if (in_b) begin
                                        num_b_q <= '0;
                                        b_ent_q <= 1'b0;
                                    end else begin
                                        num_a_q <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end

                    ST_VALUE_IGUAL: begin
                        if (is_digit(key_q)) begin
                            num_a_q   <= WIDTH'(key_q);
                            num_b_q   <= '0;
                            cnt_q     <= CW'(1);
                            ent_ovf_q <= 1'b0;
                            state_q   <= ST_VALUE_A;
                        end else if (is_operator(key_q)) begin
                            num_a_q <= result;
                            num_b_q <= '0;
                            op_q    <= (key_q == KEY_SUB);
                            cnt_q   <= '0;
                            b_ent_q <= 1'b0;
                            state_q <= ST_VALUE_B;
                        end else begin
                            case (key_q)
                                KEY_SAVE: begin
                                    mem_out_q <= result;
                                    mem_wr_q  <= 1'b1;
                                end
                                KEY_RECOVERY: begin
                                    num_a_q   <= memoryIn;
                                    num_b_q   <= '0;
                                    cnt_q     <= '0;
                                    ent_ovf_q <= 1'b0;
                                    state_q   <= ST_VALUE_A;
                                end
                                KEY_CE: begin
                                    num_a_q   <= '0;
                                    num_b_q   <= '0;
                                    cnt_q     <= '0;
                                    ent_ovf_q <= 1'b0;
                                    b_ent_q   <= 1'b0;
                                    state_q   <= ST_VALUE_A;
                                end
                                default: ;
                            endcase
                        end
                    end

                    ST_ERROR: begin
                        if (key_q == KEY_CE) begin
                            num_a_q   <= '0;
                            num_b_q   <= '0;
                            cnt_q     <= '0;
                            ent_ovf_q <= 1'b0;
                            b_ent_q   <= 1'b0;
                            state_q   <= ST_VALUE_A;
                        end
                    end
                endcase
            end
        end
    end

    assign numberA   = num_a_q;
    assign numberB   = num_b_q;
    assign operation = op_q;
    assign memoryOut = mem_out_q;
    assign memWrite  = mem_wr_q;
    assign keyAck    = key_ack_q;
    assign entryOvf  = ent_ovf_q;
    assign estate    = state_q;

endmodule
